// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART family: FSM encodings,
// parity mode constants and a frame-length helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                      input int parity_mode, input int stop_bits);
    return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake and line outputs of the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; bit_end marks the last clock of each bit.
// Holding restart parks the count at zero so the next bit starts cleanly.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic restart,
  output logic bit_end
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg + CW'(1);
    if (restart || (cnt_reg == LAST)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign bit_end = (cnt_reg == LAST);
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload LSB first, optional parity,
// 1 or 2 stop bits, and a one-entry holding buffer for gapless back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic          i_Clock,
  input logic          i_Reset,
  uart_tx_cfg_if.slave tx
);
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] buf_data_reg, buf_data_next;
  logic [IW-1:0]        bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 buf_valid_reg, buf_valid_next;
  logic                 ready_reg, ready_next;
  logic                 serial_reg, serial_next;
  logic                 active_reg, active_next;
  logic                 load, done_c, bit_end, accept, timer_restart;

  assign timer_restart = (state_reg == IDLE);
  assign accept        = tx.i_Tx_DV && ready_reg;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .restart (timer_restart),
    .bit_end (bit_end)
  );

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_idx_next   = bit_idx_reg;
    stop_idx_next  = stop_idx_reg;
    buf_valid_next = buf_valid_reg;
    buf_data_next  = buf_data_reg;
    load           = 1'b0;
    done_c         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (buf_valid_reg) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == LAST_IDX) begin
            state_next    = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx_reg + IW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next    = STOP;
          stop_idx_next = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (STOP_BITS == 1 || stop_idx_reg) begin
            done_c = 1'b1;
            // A waiting byte chains straight into the next start bit.
            if (buf_valid_reg) begin
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      shift_next     = buf_data_reg;
      buf_valid_next = 1'b0;
      bit_idx_next   = '0;
    end
    if (accept) begin
      buf_valid_next = 1'b1;
      buf_data_next  = tx.i_Tx_Byte;
    end

    ready_next  = !buf_valid_next;
    active_next = (state_next != IDLE);

    // The line register takes the level of the state being entered.
    serial_next = 1'b1;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[bit_idx_next];
      PARITY:  serial_next = (PARITY_MODE == PARITY_EVEN) ? ^shift_next : ~^shift_next;
      default: serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      buf_data_reg  <= '0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      buf_valid_reg <= 1'b0;
      ready_reg     <= 1'b1;
      serial_reg    <= 1'b1;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      buf_data_reg  <= buf_data_next;
      bit_idx_reg   <= bit_idx_next;
      stop_idx_reg  <= stop_idx_next;
      buf_valid_reg <= buf_valid_next;
      ready_reg     <= ready_next;
      serial_reg    <= serial_next;
      active_reg    <= active_next;
    end
  end

  assign tx.o_Tx_Ready  = ready_reg;
  assign tx.o_Tx_Active = active_reg;
  assign tx.o_Tx_Serial = serial_reg;
  assign tx.o_Tx_Done   = done_c;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: six configurations side by side, a frame-level reference
// model checked every cycle, plus directed vectors with hand-computed waveforms.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int NI = 6;
    localparam int CPB_T [NI] = '{4, 4, 4, 4, 2, 2};
    localparam int DB_T  [NI] = '{8, 8, 8, 7, 5, 9};
    localparam int PM_T  [NI] = '{0, 2, 1, 0, 0, 0};
    localparam int SB_T  [NI] = '{1, 1, 1, 2, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [NI];
    logic       dv  [NI];
    logic [8:0] tx_byte [NI];
    logic       ser [NI];
    logic       rdy [NI];
    logic       act [NI];
    logic       dn  [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        uart_tx_cfg_if #(.DATA_BITS(DB_T[gi])) ifc ();
        assign ifc.i_Tx_DV   = dv[gi];
        assign ifc.i_Tx_Byte = tx_byte[gi][DB_T[gi]-1:0];
        assign ser[gi] = ifc.o_Tx_Serial;
        assign rdy[gi] = ifc.o_Tx_Ready;
        assign act[gi] = ifc.o_Tx_Active;
        assign dn[gi]  = ifc.o_Tx_Done;
        uart_tx_cfg #(
            .CLKS_PER_BIT (CPB_T[gi]),
            .DATA_BITS    (DB_T[gi]),
            .PARITY_MODE  (PM_T[gi]),
            .STOP_BITS    (SB_T[gi])
        ) dut (
            .i_Clock (clk),
            .i_Reset (rst[gi]),
            .tx      (ifc)
        );
    end

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    // Reference model: frame as a list of line levels, pos = cycle within frame.
    int         pos  [NI];
    int         flen [NI];
    bit         fb   [NI][16];
    bit         bufv [NI];
    logic [8:0] bufd [NI];

    bit cap_ser [256];
    bit cap_act [256];
    bit cap_dn  [256];
    bit cap_rdy [256];

    task automatic chk(input string name, input int act_v, input int exp_v);
        n_chk++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic model_build(input int i, input logic [8:0] d);
        int n;
        bit p;
        n = 0;
        p = 1'b0;
        fb[i][n] = 1'b0; n++;
        for (int k = 0; k < DB_T[i]; k++) begin
            fb[i][n] = d[k]; n++;
            p ^= d[k];
        end
        if (PM_T[i] != PARITY_NONE) begin
            fb[i][n] = (PM_T[i] == PARITY_EVEN) ? p : !p; n++;
        end
        for (int s = 0; s < SB_T[i]; s++) begin
            fb[i][n] = 1'b1; n++;
        end
        flen[i] = n;
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst[i]) begin
                    pos[i]  = -1;
                    bufv[i] = 1'b0;
                end else begin
                    bit acc;
                    acc = dv[i] && !bufv[i];
                    if (pos[i] >= 0 && pos[i] < flen[i] * CPB_T[i] - 1) begin
                        pos[i]++;
                    end else if (bufv[i]) begin
                        model_build(i, bufd[i]);
                        pos[i]  = 0;
                        bufv[i] = 1'b0;
                    end else begin
                        pos[i] = -1;
                    end
                    if (acc) begin
                        bufv[i] = 1'b1;
                        bufd[i] = tx_byte[i] & ((9'd1 << DB_T[i]) - 9'd1);
                    end
                end
            end
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < NI; i++) begin
                    int es, ed, ea;
                    es = (pos[i] < 0) ? 1 : int'(fb[i][pos[i] / CPB_T[i]]);
                    ed = (pos[i] >= 0 && pos[i] == flen[i] * CPB_T[i] - 1) ? 1 : 0;
                    ea = (pos[i] >= 0) ? 1 : 0;
                    chk($sformatf("serial[%0d]", i), ser[i], es);
                    chk($sformatf("done[%0d]", i), dn[i], ed);
                    chk($sformatf("active[%0d]", i), act[i], ea);
                    chk($sformatf("ready[%0d]", i), rdy[i], bufv[i] ? 0 : 1);
                end
            end
        end
    endtask

    // Called just after a rising edge; holds valid until the byte is taken.
    task automatic send(input int i, input logic [8:0] b);
        int w;
        dv[i] = 1'b1;
        tx_byte[i] = b;
        w = 0;
        while (!rdy[i] && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk($sformatf("send_ready[%0d]", i), rdy[i], 1);
        @(posedge clk); #1;
        dv[i] = 1'b0;
        $display("tx inst %0d byte 0x%0h accepted after %0d wait cycles", i, b, w);
    endtask

    // Waits for a start bit, then records ncyc cycles beginning with it.
    task automatic grab(input int i, input int ncyc);
        int w;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (ser[i] != 1'b0 && w < 300);
        chk($sformatf("start_seen[%0d]", i), ser[i], 0);
        for (int c = 0; c < ncyc; c++) begin
            cap_ser[c] = ser[i];
            cap_act[c] = act[i];
            cap_dn[c]  = dn[i];
            cap_rdy[c] = rdy[i];
            if (c < ncyc - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    function automatic int first_done(input int from, input int ncyc);
        for (int c = from; c < ncyc; c++) if (cap_dn[c]) return c;
        return -1;
    endfunction

    function automatic int decode(input int base, input int cpb, input int db);
        int v;
        v = 0;
        for (int k = 0; k < db; k++) v |= int'(cap_ser[base + (1 + k) * cpb + cpb / 2]) << k;
        return v;
    endfunction

    task automatic check_line(input string tag, input int cpb, input int nbits, input logic [15:0] expv);
        for (int b = 0; b < nbits; b++)
            chk($sformatf("%s_bit%0d", tag, b), cap_ser[b * cpb + cpb / 2], int'(expv[b]));
    endtask

    initial begin
        int d1, d2, cnt, bad_low, bad_done;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; dv[i] = 1'b0; tx_byte[i] = '0;
            pos[i] = -1; flen[i] = 1; bufv[i] = 1'b0; bufd[i] = '0;
        end
        fork
            model_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_serial[%0d]", i), ser[i], 1);
            chk($sformatf("rst_ready[%0d]", i), rdy[i], 1);
            chk($sformatf("rst_active[%0d]", i), act[i], 0);
            chk($sformatf("rst_done[%0d]", i), dn[i], 0);
            rst[i] = 1'b0;
        end
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1 0x55 at 4 clocks per bit.
        send(0, 9'h055);
        chk("8n1_ready_low_after_accept", rdy[0], 0);
        grab(0, 44);
        chk("8n1_ready_high_next", cap_rdy[0], 1);
        check_line("8n1_55", 4, 10, 16'b10_1010_1010);
        chk("8n1_done_cycle", first_done(0, 44) + 1, 40);
        chk("8n1_done_once", first_done(40, 44), -1);

        // 8E1 and 8O1 with 0x07.
        send(1, 9'h007);
        grab(1, 48);
        chk("8e1_parity", cap_ser[9 * 4 + 2], 1);
        chk("8e1_done_cycle", first_done(0, 48) + 1, 44);
        send(2, 9'h007);
        grab(2, 48);
        chk("8o1_parity", cap_ser[9 * 4 + 2], 0);
        chk("8o1_done_cycle", first_done(0, 48) + 1, 44);
        chk("8o1_byte", decode(0, 4, 8), 8'h07);

        // 7N2 back-to-back; the second byte arrives during the first frame's data.
        send(3, 9'h041);
        fork
            grab(3, 85);
            begin
                repeat (8) @(posedge clk);
                #1;
                send(3, 9'h042);
            end
        join
        d1 = first_done(0, 85);
        d2 = first_done(d1 + 1, 85);
        chk("7n2_first_done", d1 + 1, 40);
        chk("7n2_done_spacing", d2 - d1, 40);
        chk("7n2_last_stop", cap_ser[39], 1);
        chk("7n2_second_start", cap_ser[40], 0);
        cnt = 0;
        for (int c = 0; c < 80; c++) if (!cap_act[c]) cnt++;
        chk("7n2_active_drops", cnt, 0);
        chk("7n2_byte0", decode(0, 4, 7), 7'h41);
        chk("7n2_byte1", decode(40, 4, 7), 7'h42);
        repeat (4) @(posedge clk);
        #1;

        // Buffer full with a third byte held valid; output order must hold.
        send(0, 9'h0A1);
        fork
            grab(0, 125);
            begin
                repeat (6) @(posedge clk);
                #1;
                send(0, 9'h022);
                send(0, 9'h099);
            end
        join
        chk("order_byte0", decode(0, 4, 8), 8'hA1);
        chk("order_byte1", decode(40, 4, 8), 8'h22);
        chk("order_byte2", decode(80, 4, 8), 8'h99);
        chk("order_third_done", first_done(80, 125) + 1, 120);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-DATA with a byte buffered.
        send(0, 9'h033);
        repeat (12) @(posedge clk);
        #1;
        send(0, 9'h044);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_serial", ser[0], 1);
        chk("rst_mid_ready", rdy[0], 1);
        chk("rst_mid_active", act[0], 0);
        rst[0] = 1'b0;
        bad_low = 0;
        bad_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (!ser[0]) bad_low++;
            if (dn[0]) bad_done++;
        end
        chk("rst_no_frame", bad_low, 0);
        chk("rst_no_done", bad_done, 0);

        // 5N1 and 9N1 at 2 clocks per bit.
        send(4, 9'h015);
        grab(4, 20);
        check_line("5n1_15", 2, 7, 16'b110_1010);
        cnt = 0;
        for (int c = 0; c < 20; c++) if (cap_act[c]) cnt++;
        chk("5n1_active_len", cnt, 14);
        chk("5n1_done_cycle", first_done(0, 20) + 1, 14);
        send(5, 9'h1A5);
        grab(5, 30);
        check_line("9n1_1a5", 2, 11, 16'b111_0100_1010);
        cnt = 0;
        for (int c = 0; c < 30; c++) if (cap_act[c]) cnt++;
        chk("9n1_active_len", cnt, 22);
        chk("9n1_byte", decode(0, 2, 9), 9'h1A5);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter. It is the next generation of the fixed 8N1 transmitter.
- Adds configurable data width, optional odd/even parity and 1 or 2 stop bits.
- Adds a one-entry holding buffer with a valid/ready handshake, so back-to-back frames go out with no idle gap.
- Sits between the bridge's byte source (the I2C-side FIFO or control logic) and the physical TX pin.

Parameters:
- CLKS_PER_BIT, 87: clock cycles per bit, equal to clock frequency / baud rate. Minimum 2.
- DATA_BITS, 8: payload bits per frame, legal range 5..9, sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even. Values 3 and above are illegal; add an elaboration check.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- i_Clock  in  1  system clock; all logic is on the rising edge.
- i_Reset  in  1  synchronous reset, active-high.
- i_Tx_DV  in  1  producer valid; a byte is accepted on any edge where i_Tx_DV and o_Tx_Ready are both high.
- i_Tx_Byte  in  DATA_BITS  payload, sampled on accept.
- o_Tx_Ready  out  1  holding buffer is empty; equals NOT buf_valid, driven from a register.
- o_Tx_Active  out  1  high while a frame is on the line (start through the last stop bit).
- o_Tx_Serial  out  1  registered serial line; idle level is 1.
- o_Tx_Done  out  1  one-cycle pulse on the last clock of the final stop bit of each frame.

Behaviour:
- Clock i_Clock only; reset i_Reset is synchronous and active-high.
- Reset values:
  - state = IDLE, buf_valid = 0, clock counter = 0, bit index = 0.
  - o_Tx_Serial = 1, o_Tx_Ready = 1, o_Tx_Active = 0, o_Tx_Done = 0.
  - Reset mid-frame aborts the frame. The line is high on the cycle after the reset edge and the buffered byte is discarded.
- Holding buffer:
  - Accept loads buf_data and sets buf_valid.
  - The FSM clears buf_valid when it moves the byte into the shift register.
  - No bypass: a byte cannot be accepted on the same edge that drains a full buffer, because ready was low that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_Tx_Serial = 1. If buf_valid, load the shift register, clear buf_valid and go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: line = shift[bit_idx] for CLKS_PER_BIT cycles per bit, for bit_idx 0..DATA_BITS-1. Then go to PARITY if PARITY_MODE != 0, else to STOP.
  - PARITY: line = XOR of the payload for even mode, or its inverse for odd mode (the total count of ones becomes odd). Held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line 1 for STOP_BITS × CLKS_PER_BIT cycles.
    - On the final cycle, pulse o_Tx_Done.
    - If buf_valid, load the next byte and go directly to START (no idle cycle).
    - Otherwise go to IDLE.
- Latency: byte accepted at edge E0 → FSM leaves IDLE at E1 → o_Tx_Serial is 0 from E1.
  - Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × CLKS_PER_BIT cycles.
- o_Tx_Active:
  - Set on the IDLE→START transition; cleared on the STOP→IDLE transition.
  - Stays high continuously across back-to-back frames.
- Widths:
  - Clock counter is $clog2(CLKS_PER_BIT) bits; it wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_BITS) bits.
  - The stop-bit counter is a 1-bit count when STOP_BITS = 2.
- Boundaries:
  - i_Tx_DV held high while ready is low has no effect, and the byte is not consumed.
  - A new byte may be accepted during any state, as long as buf_valid is 0.

Decomposition:
- Package uart_pkg holds:
  - state encodings (3-bit localparams);
  - PARITY_NONE/ODD/EVEN constants;
  - a frame-length helper function for benches.
- One sub-module: uart_bit_timer, a CLKS_PER_BIT counter with a restart input and a one-cycle bit_end output. It is intended for reuse by the future uart_rx_cfg.

Test Plan:
- CLKS_PER_BIT=4, 8N1, byte 0x55 → line reads 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit; o_Tx_Done pulses at cycle 40 after the start edge; ready is high again 1 cycle after accept.
- 8E1, byte 0x07 → parity bit 1; 8O1, byte 0x07 → parity bit 0; frame length 44 cycles.
- 7N2, bytes 0x41 then 0x42 presented back-to-back:
  - second byte accepted while the first is in DATA;
  - second start bit begins on the cycle after the first frame's last stop cycle;
  - o_Tx_Active never drops;
  - two Done pulses, 40 cycles apart.
- Buffer full with i_Tx_DV held high plus a third byte 0x99 → 0x99 is accepted only after the second byte moves to the shift register; the output order is preserved.
- Reset asserted mid-DATA with a byte buffered → line 1 and ready 1 on the next cycle, no Done pulse, the buffered byte is never transmitted.
- 5N1 and 9N1 at CLKS_PER_BIT=2 → exact bit counts and LSB-first order for 0x15 and 0x1A5.
